// File: rtl/bus_req_arbiter.sv
// Merges NUM_PORTS core-side req/ack memory channels onto one memory port (fixed-priority or round-robin).
// Latency: port req sampled -> mem_req next cycle; mem_ack -> port_ack next cycle; one RESP cycle between grants.
// Backpressure: requesters hold req until their ack; memory stalls by withholding mem_ack, bounded by an optional timeout.
module bus_req_arbiter #(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int ARB_MODE       = 0,
   parameter int TIMEOUT_CYCLES = 0,
   localparam int MW = DATA_WIDTH / 8,
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk_i,
   input  logic                            rstz_i,
   input  logic [NUM_PORTS-1:0]            port_req_i,
   input  logic [NUM_PORTS-1:0]            port_we_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata_i,
   input  logic [NUM_PORTS*MW-1:0]         port_mask_i,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] port_rdata_o,
   output logic [NUM_PORTS-1:0]            port_ack_o,
   output logic [NUM_PORTS-1:0]            port_err_o,
   output logic                            mem_req_o,
   output logic                            mem_we_o,
   output logic [ADDR_WIDTH-1:0]           mem_addr_o,
   output logic [DATA_WIDTH-1:0]           mem_wdata_o,
   output logic [MW-1:0]                   mem_mask_o,
   input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
   input  logic                            mem_ack_i,
   output logic                            busy_o,
   output logic [GW-1:0]                   grant_id_o
);

   // Timeout counter only needs to reach TIMEOUT_CYCLES-1; the limit cycle itself ends the wait.
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TLIM = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // One latched memory command, as presented on the mem_* side.
   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [MW-1:0]         mask;
   } cmd_t;

   state_t                          state_q;
   cmd_t                            cmd_q;
   cmd_t                            cmd_d;
   logic                            mem_req_q;
   logic [GW-1:0]                   gnt_q;
   logic [GW-1:0]                   gnt_d;
   logic [GW-1:0]                   ptr_q;
   logic [GW-1:0]                   ptr_d;
   logic [NUM_PORTS-1:0]            gnt_oh;
   logic [NUM_PORTS-1:0]            ack_q;
   logic [NUM_PORTS-1:0]            err_q;
   logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q;
   logic [TW-1:0]                   tmo_q;
   logic                            tmo_hit;
   logic                            any_req;
   int                              sel_idx;

   // Winner selection: search starts at port 0 (fixed) or at the round-robin pointer; the
   // loop runs backwards so the last hit written is the first port in search order.
   always_comb begin
      gnt_d   = '0;
      sel_idx = 0;
      any_req = |port_req_i;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         sel_idx = (ARB_MODE == 1) ? int'(ptr_q) + k : k;
         if (sel_idx >= NUM_PORTS) begin
            sel_idx = sel_idx - NUM_PORTS;
         end
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (j == sel_idx && port_req_i[j]) begin
               gnt_d = GW'(j);
            end
         end
      end
   end

   // Gather the winner's command fields out of the flattened port buses.
   always_comb begin
      cmd_d = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (GW'(j) == gnt_d) begin
            cmd_d.we    = port_we_i[j];
            cmd_d.addr  = port_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
            cmd_d.wdata = port_wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
            cmd_d.mask  = port_mask_i[j*MW +: MW];
         end
      end
   end

   // Pointer moves just past the winner so it becomes the lowest priority next round.
   assign ptr_d = (int'(gnt_d) == NUM_PORTS - 1) ? '0 : gnt_d + 1'b1;

   // Decode the held grant index into a per-port strobe for ack/err/rdata steering.
   always_comb begin
      gnt_oh = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         gnt_oh[j] = (GW'(j) == gnt_q);
      end
   end

   assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TLIM);

   // Transaction FSM: grant in IDLE, hold the memory command in WAIT, pulse ack/err in RESP.
   always_ff @(posedge clk_i) begin
      if (!rstz_i) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         mem_req_q <= 1'b0;
         gnt_q     <= '0;
         ptr_q     <= '0;
         ack_q     <= '0;
         err_q     <= '0;
         rdata_q   <= '0;
         tmo_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  cmd_q     <= cmd_d;
                  mem_req_q <= 1'b1;
                  gnt_q     <= gnt_d;
                  ptr_q     <= ptr_d;
                  tmo_q     <= '0;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A real ack on the limit cycle takes precedence over the timeout.
               if (mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  ack_q     <= gnt_oh;
                  if (!cmd_q.we) begin
                     for (int j = 0; j < NUM_PORTS; j++) begin
                        if (gnt_oh[j]) begin
                           rdata_q[j*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata_i;
                        end
                     end
                  end
                  state_q <= S_RESP;
               end else if (tmo_hit) begin
                  mem_req_q <= 1'b0;
                  ack_q     <= gnt_oh;
                  err_q     <= gnt_oh;
                  state_q   <= S_RESP;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_RESP: begin
               ack_q   <= '0;
               err_q   <= '0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign port_rdata_o = rdata_q;
   assign port_ack_o   = ack_q;
   assign port_err_o   = err_q;
   assign mem_req_o    = mem_req_q;
   assign mem_we_o     = cmd_q.we;
   assign mem_addr_o   = cmd_q.addr;
   assign mem_wdata_o  = cmd_q.wdata;
   assign mem_mask_o   = cmd_q.mask;
   assign busy_o       = (state_q != S_IDLE);
   assign grant_id_o   = gnt_q;

endmodule

// File: doc/bus_req_arbiter.md
Name: bus_req_arbiter

Overview:
- Parametrised N-port arbiter that merges several core-side req/ack memory channels onto one Controller-side memory port.
- Typical use: instruction and data channels, plus optional DMA/debug masters.
- Each transaction is latched, issued with a registered handshake, and answered on the winning port only.
- Selectable fixed-priority or round-robin arbitration; optional bus-timeout error response.

Parameters:
- NUM_PORTS, 2, number of requesting channels (>=1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYCLES, 0, WAIT cycles before error completion; 0 disables the timeout.
- Derived: MW = DATA_WIDTH/8; GW = max(1, clog2(NUM_PORTS)).

Ports:
- clk  in  1  single clock for the whole block.
- rstz  in  1  synchronous reset, active-low.
- port_req  in  NUM_PORTS  per-port request; held high until that port's ack.
- port_we  in  NUM_PORTS  per-port write enable (1 = write).
- port_addr  in  NUM_PORTS*ADDR_WIDTH  flattened addresses; port i occupies slice i.
- port_wdata  in  NUM_PORTS*DATA_WIDTH  flattened write data.
- port_mask  in  NUM_PORTS*MW  flattened byte enables.
- port_rdata  out  NUM_PORTS*DATA_WIDTH  flattened read data, registered.
- port_ack  out  NUM_PORTS  one-cycle completion pulse.
- port_err  out  NUM_PORTS  one-cycle error pulse, coincident with port_ack on timeout.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_mask  out  MW  memory byte enables.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- busy  out  1  high in WAIT and RESP.
- grant_id  out  GW  index of the current or last granted port.

Behaviour:
- Reset (rstz=0 at a clk edge): state IDLE.
  - All outputs 0, including port_rdata and grant_id.
  - RR pointer 0; timeout counter 0.
  - Any in-flight transaction is abandoned; no ack is produced for it.
- FSM states: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any port_req is high, select winner W.
  - Latch W's we/addr/wdata/mask into mem_*; set mem_req=1 and grant_id=W.
  - Enter WAIT. These outputs are registered, so mem_req rises on the cycle after req is sampled.
  - If no request, mem_req stays 0.
- Fixed-priority selection: lowest index with req high.
- Round-robin selection: first requester at or after the pointer, searching pointer, pointer+1, ... modulo NUM_PORTS.
  - Pointer <= W+1 (mod NUM_PORTS) on every grant.
- WAIT:
  - mem_req and mem_* held stable until mem_ack.
  - On mem_ack: mem_req <= 0; port_ack[W] <= 1; if !mem_we, port_rdata[W] <= mem_rdata. Enter RESP.
  - A mem_ack that coincides with the first mem_req cycle is accepted.
- RESP: port_ack/port_err high for exactly this one cycle, then IDLE. Requests are not sampled in RESP.
- Minimum latency: port_req at cycle 0 -> mem_req at cycle 1 -> (mem_ack at cycle 1) -> port_ack at cycle 2. The next grant's mem_req is at cycle 4 at the earliest.
- Timeout (TIMEOUT_CYCLES > 0):
  - Counter clears on entering WAIT and increments each WAIT cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES: mem_req <= 0; port_ack[W] = port_err[W] = 1 in RESP; port_rdata[W] unchanged.
  - If mem_ack arrives on the same cycle the limit is reached, the ack wins and no error is reported.
- mem_ack seen in IDLE or RESP (late or spurious) is ignored.
- port_rdata[i] changes only on a successful read completion for port i; otherwise it holds.
- port_req dropped by a requester before its grant: it is simply not selected. Dropping req after grant is illegal; the transaction still completes.
- NUM_PORTS=1: pure registered pass-through with identical timing; grant_id is always 0.

Test Plan:
- Single read, port 0: addr=0x100; mem_ack one cycle after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, port_ack[0] one pulse, port_rdata[0]=0xDEADBEEF, port_rdata[1] stays 0.
- Fixed priority (ARB_MODE=0), ports 0 and 1 request together continuously -> grant_id=0 every time; port 1 is never served while port 0 holds req.
- Round-robin (ARB_MODE=1, NUM_PORTS=3), all three request continuously -> grant order 0,1,2,0,1,2; each port_ack pulses once per three transactions.
- Write port 1: addr=0x2000, wdata=0x12345678, mask=4'b0011 -> mem_we=1, mem_mask=0011, mem_wdata=0x12345678; port_ack[1] pulses; port_rdata[1] unchanged.
- Timeout (TIMEOUT_CYCLES=8), no mem_ack -> mem_req drops after 8 WAIT cycles; port_ack[0] and port_err[0] pulse together.
  - A mem_ack arriving 3 cycles later is ignored; the next request proceeds normally.
- Reset in WAIT: rstz=0 for one cycle, mem_ack pulses afterwards -> all outputs 0 and no port_ack.
  - With ARB_MODE=1, the next round-robin grant starts at port 0.
